// File: rtl/apb_master_cmd.sv
// APB4 requester: turns a valid/ready command stream into SETUP/ACCESS transfers, one response per command.
// Define APB_MASTER_INC_EN to enable op 10 (read, add cmd_wdata, write back); otherwise op 10 is reserved.
module apb_master_cmd #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_W-1:0]     cmd_addr_i,
    input  logic [DATA_W-1:0]     cmd_wdata_i,
    input  logic [DATA_W/8-1:0]   cmd_strb_i,
    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic [ADDR_W-1:0]     paddr_o,
    output logic                  pwrite_o,
    output logic [DATA_W-1:0]     pwdata_o,
    output logic [DATA_W/8-1:0]   pstrb_o,
    input  logic                  pready_i,
    input  logic [DATA_W-1:0]     prdata_i,
    input  logic                  pslverr_i
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort fires on the TIMEOUT-th low-ready ACCESS cycle, when the counter holds TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_ACCESS  = 3'd2,
        S_WSETUP  = 3'd3,
        S_WACCESS = 3'd4,
        S_RSVD    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_to_q, rsp_to_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                op_apb_s;
    logic                timeout_hit_s;
`ifdef APB_MASTER_INC_EN
    logic                inc_q, inc_d;
    logic [DATA_W-1:0]   inc_amt_q, inc_amt_d, rd_q, rd_d;

    assign op_apb_s = (cmd_op_i != 2'b11);
`else
    assign op_apb_s = (cmd_op_i[1] == 1'b0);
`endif

    assign cmd_ready_o   = (state_q == S_IDLE);
    assign timeout_hit_s = (TIMEOUT != 0) && !pready_i && (cnt_q == CNT_LAST);

    // Next-state, APB drive and response computation.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
`ifdef APB_MASTER_INC_EN
        inc_d       = inc_q;
        inc_amt_d   = inc_amt_q;
        rd_d        = rd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && op_apb_s) begin
                    state_d   = S_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = cmd_addr_i;
                    pwrite_d  = (cmd_op_i == 2'b01);
                    pwdata_d  = cmd_wdata_i;
                    pstrb_d   = (cmd_op_i == 2'b01) ? cmd_strb_i : {STRB_W{1'b0}};
`ifdef APB_MASTER_INC_EN
                    inc_d     = (cmd_op_i == 2'b10);
                    inc_amt_d = cmd_wdata_i;
`endif
                end else if (cmd_valid_i) begin
                    state_d = S_RSVD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP, S_WSETUP: begin
                state_d   = (state_q == S_SETUP) ? S_ACCESS : S_WACCESS;
                penable_d = 1'b1;
                cnt_d     = {CNT_W{1'b0}};
            end
            S_ACCESS, S_WACCESS: begin
                if (pready_i) begin
`ifdef APB_MASTER_INC_EN
                    if (state_q == S_ACCESS && inc_q && !pslverr_i) begin
                        state_d   = S_WSETUP;
                        penable_d = 1'b0;
                        pwrite_d  = 1'b1;
                        pwdata_d  = prdata_i + inc_amt_q;
                        pstrb_d   = {STRB_W{1'b1}};
                        rd_d      = prdata_i;
                    end else begin
                        state_d     = S_IDLE;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = pslverr_i;
                        rsp_to_d    = 1'b0;
                        rsp_rdata_d = (state_q == S_WACCESS) ? rd_q :
                                      (pwrite_q ? {DATA_W{1'b0}} : prdata_i);
                    end
`else
                    state_d     = S_IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr_i;
                    rsp_to_d    = 1'b0;
                    rsp_rdata_d = pwrite_q ? {DATA_W{1'b0}} : prdata_i;
`endif
                end else if (timeout_hit_s) begin
                    state_d     = S_IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                    rsp_rdata_d = {DATA_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RSVD: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_to_d    = 1'b0;
                rsp_rdata_d = {DATA_W{1'b0}};
            end
            default: begin
                state_d   = S_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State, APB output and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= {ADDR_W{1'b0}};
            pwrite_q    <= 1'b0;
            pwdata_q    <= {DATA_W{1'b0}};
            pstrb_q     <= {STRB_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

`ifdef APB_MASTER_INC_EN
    // Increment-only command state: flag, addend and the original read value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_q     <= 1'b0;
            inc_amt_q <= {DATA_W{1'b0}};
            rd_q      <= {DATA_W{1'b0}};
        end else begin
            inc_q     <= inc_d;
            inc_amt_q <= inc_amt_d;
            rd_q      <= rd_d;
        end
    end
`endif

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_to_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign paddr_o       = paddr_q;
    assign pwrite_o      = pwrite_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
endmodule

// File: tb/tb_apb_master_cmd.sv
// Directed bench for apb_master_cmd (TIMEOUT=4); expected responses are queued at issue and checked on rsp_valid_o.
module tb_apb_master_cmd;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i = 2'b00;
    logic [31:0] cmd_addr_i = 32'h0;
    logic [31:0] cmd_wdata_i = 32'h0;
    logic [3:0]  cmd_strb_i = 4'h0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        psel_o;
    logic        penable_o;
    logic [31:0] paddr_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic        pready_i = 1'b1;
    logic [31:0] prdata_i = 32'h0;
    logic        pslverr_i = 1'b0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    apb_master_cmd #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
        .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
        .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        chk({tag, "_ready"}, {63'h0, cmd_ready_o}, 64'h1);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        cmd_strb_i  = strb;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int budget, input int exp_lat);
        int   n;
        logic found;
        rsp_t e;
        n = 0;
        found = 1'b0;
        while (!found && n <= budget) begin
            if (rsp_valid_o === 1'b1) found = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        chk({tag, "_rsp_seen"}, {63'h0, found}, 64'h1);
        if (found) begin
            chk({tag, "_rsp_lat"}, 64'(n), 64'(exp_lat));
            chk({tag, "_q_nonempty"}, {63'h0, exp_q.size() != 0}, 64'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk({tag, "_rdata"}, {32'h0, rsp_rdata_o}, {32'h0, e.rdata});
                chk({tag, "_err"}, {63'h0, rsp_err_o}, {63'h0, e.err});
                chk({tag, "_timeout"}, {63'h0, rsp_timeout_o}, {63'h0, e.to});
            end
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_psel", {63'h0, psel_o}, 64'h0);
        chk("rst_penable", {63'h0, penable_o}, 64'h0);
        chk("rst_ready", {63'h0, cmd_ready_o}, 64'h1);
        chk("rst_rsp_valid", {63'h0, rsp_valid_o}, 64'h0);
        chk("rst_paddr", {32'h0, paddr_o}, 64'h0);
        reset = 1'b0;
        tick();

        // Zero-wait write
        pready_i = 1'b1;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        issue("wr", 2'b01, 32'hDEADCAFE, 32'h12345678, 4'hF);
        chk("wr_setup_psel", {63'h0, psel_o}, 64'h1);
        chk("wr_setup_penable", {63'h0, penable_o}, 64'h0);
        chk("wr_paddr", {32'h0, paddr_o}, 64'hDEADCAFE);
        chk("wr_pwrite", {63'h0, pwrite_o}, 64'h1);
        chk("wr_pwdata", {32'h0, pwdata_o}, 64'h12345678);
        chk("wr_pstrb", {60'h0, pstrb_o}, 64'hF);
        chk("wr_busy_ready", {63'h0, cmd_ready_o}, 64'h0);
        tick();
        chk("wr_access_penable", {63'h0, penable_o}, 64'h1);
        tick();
        wait_rsp("wr", 0, 0);
        chk("wr_rsp_psel", {63'h0, psel_o}, 64'h0);
        tick();
        chk("wr_pulse", {63'h0, rsp_valid_o}, 64'h0);
        chk("wr_hold_paddr", {32'h0, paddr_o}, 64'hDEADCAFE);

        // Read with two wait states
        pready_i = 1'b0;
        prdata_i = 32'hA5A5A5A5;
        exp_q.push_back('{rdata: 32'hA5A5A5A5, err: 1'b0, to: 1'b0});
        issue("rd", 2'b00, 32'h10, 32'h0, 4'hF);
        chk("rd_pwrite", {63'h0, pwrite_o}, 64'h0);
        chk("rd_pstrb", {60'h0, pstrb_o}, 64'h0);
        tick();
        tick();
        tick();
        chk("rd_acc3_psel", {63'h0, psel_o}, 64'h1);
        chk("rd_acc3_penable", {63'h0, penable_o}, 64'h1);
        pready_i = 1'b1;
        tick();
        wait_rsp("rd", 0, 0);

        // Timeout after four low-ready ACCESS cycles
        pready_i = 1'b0;
        prdata_i = 32'h00001234;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b1});
        issue("to", 2'b00, 32'h20, 32'h0, 4'h0);
        tick();
        tick();
        tick();
        tick();
        chk("to_acc4_psel", {63'h0, psel_o}, 64'h1);
        tick();
        chk("to_drop_psel", {63'h0, psel_o}, 64'h0);
        chk("to_drop_penable", {63'h0, penable_o}, 64'h0);
        wait_rsp("to", 0, 0);

        // Following write with slave error, issued in the timeout response cycle
        pready_i  = 1'b1;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b0});
        issue("se", 2'b01, 32'h44, 32'hCAFEF00D, 4'h3);
        chk("se_pstrb", {60'h0, pstrb_o}, 64'h3);
        chk("to_hold_timeout", {63'h0, rsp_timeout_o}, 64'h1);
        tick();
        pslverr_i = 1'b1;
        tick();
        wait_rsp("se", 0, 0);
        pslverr_i = 1'b0;
        prdata_i  = 32'h0BADBEEF;
        exp_q.push_back('{rdata: 32'h0BADBEEF, err: 1'b0, to: 1'b0});
        issue("b2b", 2'b00, 32'h48, 32'h0, 4'h0);
        chk("b2b_paddr", {32'h0, paddr_o}, 64'h48);
        chk("b2b_psel", {63'h0, psel_o}, 64'h1);
        tick();
        tick();
        wait_rsp("b2b", 0, 0);

        // Increment command
`ifdef APB_MASTER_INC_EN
        prdata_i = 32'hFFFFFFFF;
        exp_q.push_back('{rdata: 32'hFFFFFFFF, err: 1'b0, to: 1'b0});
        issue("inc", 2'b10, 32'h80, 32'h1, 4'h0);
        chk("inc_rd_pwrite", {63'h0, pwrite_o}, 64'h0);
        chk("inc_rd_pstrb", {60'h0, pstrb_o}, 64'h0);
        tick();
        tick();
        chk("inc_wsetup_psel", {63'h0, psel_o}, 64'h1);
        chk("inc_wsetup_penable", {63'h0, penable_o}, 64'h0);
        chk("inc_wsetup_pwrite", {63'h0, pwrite_o}, 64'h1);
        chk("inc_pwdata", {32'h0, pwdata_o}, 64'h0);
        chk("inc_pstrb", {60'h0, pstrb_o}, 64'hF);
        chk("inc_paddr", {32'h0, paddr_o}, 64'h80);
        tick();
        chk("inc_waccess_penable", {63'h0, penable_o}, 64'h1);
        tick();
        wait_rsp("inc", 0, 0);
`else
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b0});
        issue("inc", 2'b10, 32'h80, 32'h1, 4'h0);
        chk("inc_no_psel", {63'h0, psel_o}, 64'h0);
        chk("inc_busy_ready", {63'h0, cmd_ready_o}, 64'h0);
        tick();
        wait_rsp("inc", 0, 0);
`endif

        // Reserved op
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b0});
        issue("rsv", 2'b11, 32'h84, 32'h0, 4'h0);
        chk("rsv_no_psel", {63'h0, psel_o}, 64'h0);
        chk("rsv_busy_ready", {63'h0, cmd_ready_o}, 64'h0);
        tick();
        wait_rsp("rsv", 0, 0);

        // Reset while in ACCESS
        pready_i = 1'b0;
        issue("rstx", 2'b00, 32'h90, 32'h0, 4'h0);
        tick();
        chk("rstx_psel_pre", {63'h0, psel_o}, 64'h1);
        reset = 1'b1;
        #1;
        chk("rstx_psel", {63'h0, psel_o}, 64'h0);
        chk("rstx_penable", {63'h0, penable_o}, 64'h0);
        tick();
        reset = 1'b0;
        pready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rstx_no_rsp", {63'h0, rsp_valid_o}, 64'h0);
            tick();
        end
        chk("rstx_ready", {63'h0, cmd_ready_o}, 64'h1);
        chk("q_drained", 64'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
